// File: rtl/led_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display driver.
package led_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned SEG_VEC_W  = SEG_W * MAX_DIGITS;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  // Extracts the gfedcba field of digit d from a packed per-digit vector.
  function automatic logic [SEG_W-1:0] seg_slice(input logic [SEG_VEC_W-1:0] vec,
                                                  input int unsigned d);
    return SEG_W'(vec >> (d * SEG_W));
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Slot timebase: divides clk into digit slots and reports phase, frame boundary and frame start.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 12500,
  parameter int unsigned BLANK_CYCLES = 64,
  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [DIG_W-1:0] digit,
  output phase_t           phase_c,
  output logic             boundary_c,
  output logic             frame_tick_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  generate
    if (CLK_DIV < 2 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_timing
      $error("led_scan_timer: need CLK_DIV >= 2 and BLANK_CYCLES < CLK_DIV");
    end
  endgenerate

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_cnt_nxt;
  logic [DIG_W-1:0] digit_nxt;
  logic             slot_end;

  always_comb begin
    slot_end     = (div_cnt == CNT_W'(CLK_DIV - 1));
    div_cnt_nxt  = div_cnt + CNT_W'(1);
    digit_nxt    = digit;
    if (slot_end) begin
      div_cnt_nxt = '0;
      digit_nxt   = (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + DIG_W'(1);
    end
    phase_c      = (div_cnt < CNT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_SHOW;
    boundary_c   = slot_end && (digit == DIG_W'(NUM_DIGITS - 1));
    frame_tick_c = (div_cnt == '0) && (digit == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      digit   <= '0;
    end else begin
      div_cnt <= div_cnt_nxt;
      digit   <= digit_nxt;
    end
  end

endmodule

// File: rtl/led_scan_driver.sv
// Double-buffered, time-multiplexed driver for a common-anode seven-segment display.
module led_scan_driver
  import led_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CLK_DIV      = 12500,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic                        load,
  output logic                        load_ack,
  output logic                        frame_start,
  output logic [SEG_W-1:0]            seg_out,
  output logic                        dp_out,
  output logic [NUM_DIGITS-1:0]       an_out
);

  localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VEC_W = SEG_W * NUM_DIGITS;

  generate
    if (NUM_DIGITS == 0 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("led_scan_driver: NUM_DIGITS out of range");
    end
  endgenerate

  logic [DIG_W-1:0] digit;
  phase_t           phase_c;
  logic             boundary_c;
  logic             frame_tick_c;

  led_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .digit       (digit),
    .phase_c     (phase_c),
    .boundary_c  (boundary_c),
    .frame_tick_c(frame_tick_c)
  );

  logic [VEC_W-1:0]      staging_seg, staging_seg_nxt;
  logic [NUM_DIGITS-1:0] staging_dp,  staging_dp_nxt;
  logic [VEC_W-1:0]      shadow_seg,  shadow_seg_nxt;
  logic [NUM_DIGITS-1:0] shadow_dp,   shadow_dp_nxt;
  logic                  pending,     pending_nxt;
  logic                  load_ack_nxt;
  logic                  frame_start_nxt;
  logic [SEG_W-1:0]      seg_out_nxt;
  logic                  dp_out_nxt;
  logic [NUM_DIGITS-1:0] an_out_nxt;
  logic                  swap_c;
  logic                  show_c;

  // Swap uses the staging contents from before this cycle; a coincident load re-arms pending.
  always_comb begin
    staging_seg_nxt = staging_seg;
    staging_dp_nxt  = staging_dp;
    shadow_seg_nxt  = shadow_seg;
    shadow_dp_nxt   = shadow_dp;
    an_out_nxt      = '1;
    seg_out_nxt     = SEG_BLANK;
    dp_out_nxt      = 1'b1;

    swap_c          = boundary_c && pending;
    show_c          = (phase_c == PH_SHOW) && digit_en[digit];
    pending_nxt     = load || (pending && !boundary_c);
    load_ack_nxt    = swap_c;
    frame_start_nxt = frame_tick_c;

    if (swap_c) begin
      shadow_seg_nxt = staging_seg;
      shadow_dp_nxt  = staging_dp;
    end
    if (load) begin
      staging_seg_nxt = seg_in;
      staging_dp_nxt  = dp_in;
    end
    if (show_c) begin
      an_out_nxt  = ~(NUM_DIGITS'(1) << digit);
      seg_out_nxt = seg_slice(SEG_VEC_W'(shadow_seg), 32'(digit));
      dp_out_nxt  = ~shadow_dp[digit];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      staging_seg <= '1;
      staging_dp  <= '0;
      shadow_seg  <= '1;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
      seg_out     <= SEG_BLANK;
      dp_out      <= 1'b1;
      an_out      <= '1;
    end else begin
      staging_seg <= staging_seg_nxt;
      staging_dp  <= staging_dp_nxt;
      shadow_seg  <= shadow_seg_nxt;
      shadow_dp   <= shadow_dp_nxt;
      pending     <= pending_nxt;
      load_ack    <= load_ack_nxt;
      frame_start <= frame_start_nxt;
      seg_out     <= seg_out_nxt;
      dp_out      <= dp_out_nxt;
      an_out      <= an_out_nxt;
    end
  end

endmodule
